axi_rd_engine: RTL
==================

// Module: axi_rd_engine
// PURPOSE
//  AXI4 read-channel master directly downstream of the dcache prefetcher. Accepts one read
//  request at a time (32-byte line burst or single-word uncached), issues it on AR, gathers R
//  beats into a 256-bit buffer, and signals the first 128 bits (ret_half) and the full result
//  (ret_valid). One outstanding transaction; blocking.
// PARAMETERS
//  AXI_ID     4'd3   constant driven on arid; rid is not checked
// PORTS
//  clk        in   1    clock
//  resetn     in   1    synchronous reset, active-low
//  rd_req     in   1    read request valid
//  rd_type    in   1    1 = line burst (8 x 32b), 0 = uncached single word
//  rd_addr    in   32   byte address; line: 16B-aligned, uncached: word-aligned
//  rd_rdy     out  1    request accepted when rd_req && rd_rdy
//  ret_half   out  1    1-cycle pulse: ret_data[127:0] valid (line only)
//  ret_valid  out  1    1-cycle pulse: transaction complete, ret_data valid
//  ret_data   out  256  line: word i at [32i+31:32i]; uncached: word in [31:0], rest 0
//  arid       out  4    = AXI_ID
//  araddr     out  32   line: {rd_addr[31:4],4'b0}; uncached: rd_addr
//  arlen      out  8    line 8'd7, uncached 8'd0
//  arsize     out  3    3'd2
//  arburst    out  2    2'b01 (INCR)
//  arlock/arcache/arprot out 2/4/3  all zero
//  arvalid    out  1    AR valid
//  arready    in   1    AR ready
//  rid/rdata/rresp/rlast/rvalid in 4/32/2/1/1  R channel
//  rready     out  1    R ready
//  rd_err     out  1    sticky error flag (only with AXI_RD_ERR_CHK_EN, else tied 0)
// BEHAVIOUR
//  - Reset: state IDLE; rd_rdy=1, arvalid=0, rready=0, ret_half=0, ret_valid=0, ret_data=0,
//    araddr/arlen=0, beat counter=0, rd_err=0.
//  - FSM IDLE -> AR -> R -> DONE -> IDLE.
//    IDLE: rd_rdy=1 (only here). On accept latch type/addr into AR regs, clear beat cnt,
//          clear ret_data; next AR. arvalid rises the cycle after accept.
//    AR:   arvalid=1, AR fields stable until arvalid&&arready; next R.
//    R:    rready=1. Each rvalid&&rready writes rdata to word[cnt], cnt++ (3-bit, no wrap
//          beyond 7). Line: beat cnt==3 handshake -> ret_half=1 next cycle. Beat with
//          rlast -> DONE (rlast terminates regardless of cnt; early rlast leaves
//          unfilled words 0).
//    DONE: ret_valid=1 for exactly this cycle, ret_data complete; next IDLE.
//  - Latency: rd_req accept to arvalid 1 cycle; last R beat to ret_valid 1 cycle; min total
//    (arready/rvalid always 1) line 11 cycles, uncached 4 cycles.
//  - ret_data holds until the next accepted request. ret_half never fires for uncached.
//  - rvalid gaps: rready stays 1, counter frozen. rvalid outside R state ignored.
//  - Back-to-back: rd_rdy high in the cycle after DONE; no accept during DONE.
//  - Caller guarantees line bursts do not cross 4KB; no splitting performed.
//  - resetn low mid-transaction: immediate return to reset values; in-flight AXI burst
//    abandoned (interconnect reset concurrently).
// CONFIGURATION
//  AXI_RD_ERR_CHK_EN defined: any R beat with rresp[1]=1 sets rd_err (sticky until reset);
//    data still captured, transaction still completes normally.
//  Undefined: rresp ignored, rd_err tied 0, no error register.
// TESTING
//  T1 line read addr 0x1FC0_0010, arready=1, rdata=0xA0+i -> araddr 0x1FC0_0010 arlen 7;
//     ret_half 1 cycle after beat 3, data[127:0]=0xA3..0xA0; ret_valid after rlast, word7=0xA7.
//  T2 uncached addr 0xBFAF_8004, rdata 0x1234_5678 -> arlen 0, ret_valid once,
//     ret_data=256'h1234_5678, no ret_half.
//  T3 arready low 3 cycles, rvalid gap 2 cycles between each beat -> arvalid/araddr stable,
//     rd_rdy=0 throughout, data identical to T1.
//  T4 back-to-back line then uncached, rd_req held high -> second accepted cycle after
//     ret_valid; exactly one ret_valid per request.
//  T5 resetn low after beat 5 of line read -> next cycle rd_rdy=1, rready=0, ret_data=0,
//     no ret_valid; fresh request completes normally.
//  T6 (AXI_RD_ERR_CHK_EN) rresp=2'b10 on beat 2 -> rd_err=1 and stays 1; ret_valid still fires.

Source files
------------

// File: rtl/axi_rd_engine.sv
// AXI4 read-channel master: one outstanding line (8 x 32b INCR) or single-word read.
// Optional sticky rresp error flag enabled with `define AXI_RD_ERR_CHK_EN.
module axi_rd_engine #(
  parameter logic [3:0] AXI_ID = 4'd3
) (
  input  logic         clk,
  input  logic         resetn,
  // request / return interface
  input  logic         rd_req,
  input  logic         rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_half,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  // AXI AR channel
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  // AXI R channel
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic         rd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           type_q, type_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [255:0]   data_q, data_d;
  logic           half_q, half_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    type_d    = type_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    half_d    = 1'b0;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) begin
          type_d   = rd_type;
          araddr_d = rd_type ? {rd_addr[31:4], 4'h0} : rd_addr;
          arlen_d  = rd_type ? 8'd7 : 8'd0;
          cnt_d    = 3'd0;
          data_d   = '0;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          data_d[{cnt_q, 5'b0} +: 32] = rdata;
          // Saturate so a misbehaving slave sending >8 beats keeps overwriting word 7.
          if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
          if (type_q && cnt_q == 3'd3) half_d = 1'b1;
          if (rlast) state_d = S_DONE;
        end
      end
      S_DONE: begin
        ret_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order or process scheduling.
  always_ff @(posedge clk) begin
    // NOTE: the 256-bit return buffer is reset too, because ret_data must read
    // zero out of reset and after an abandoned transaction.
    if (!resetn) begin
      state_q  <= S_IDLE;
      type_q   <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      half_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      half_q   <= half_d;
    end
  end

  assign ret_half = half_q;
  assign ret_data = data_q;
  assign arid     = AXI_ID;
  assign araddr   = araddr_q;
  assign arlen    = arlen_q;
  assign arsize   = 3'd2;
  assign arburst  = 2'b01;
  assign arlock   = 2'b00;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;

  logic unused_in;

`ifdef AXI_RD_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (state_q == S_R && rvalid && rresp[1]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign rd_err    = err_q;
  assign unused_in = ^{rid, rresp[0]};
`else
  assign rd_err    = 1'b0;
  assign unused_in = ^{rid, rresp};
`endif

endmodule
